// File: rtl/imm_ext_pkg.sv
// Shared definitions for the pipelined immediate extension unit.
package imm_ext_pkg;

    localparam int unsigned EXT_MAX_W = 64;
    localparam int unsigned EXT_IDX_W = $clog2(EXT_MAX_W);

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } imm_mode_e;

    // Width-generic extension: imm holds in_w valid LSBs; result is masked to out_w bits.
    function automatic logic [EXT_MAX_W-1:0] ext_imm(
        input logic [EXT_MAX_W-1:0] imm,
        input imm_mode_e            mode,
        input int unsigned          in_w,
        input int unsigned          out_w
    );
        logic [EXT_MAX_W-1:0] in_mask;
        logic [EXT_MAX_W-1:0] out_mask;
        logic [EXT_MAX_W-1:0] raw;
        logic [EXT_MAX_W-1:0] sx;
        logic [EXT_MAX_W-1:0] res;
        in_mask  = (EXT_MAX_W'(1) << in_w) - EXT_MAX_W'(1);
        out_mask = (out_w >= EXT_MAX_W) ? '1 : ((EXT_MAX_W'(1) << out_w) - EXT_MAX_W'(1));
        raw      = imm & in_mask;
        sx       = raw[EXT_IDX_W'(in_w - 1)] ? (raw | ~in_mask) : raw;
        case (mode)
            MODE_SIGN:   res = sx;
            MODE_ZERO:   res = raw;
            MODE_UPPER:  res = raw << (out_w - in_w);
            MODE_BRANCH: res = sx << 2;
            default:     res = raw;
        endcase
        return res & out_mask;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Upstream/downstream handshake bundle of the immediate extension unit.
interface imm_extend_pipe_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  imm_in;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] imm_out;
    logic [1:0]       out_mode;

    // Decode-side driver and downstream consumer.
    modport master (
        output in_valid, imm_in, mode, out_ready,
        input  in_ready, out_valid, imm_out, out_mode
    );

    // The extension unit itself.
    modport slave (
        input  in_valid, imm_in, mode, out_ready,
        output in_ready, out_valid, imm_out, out_mode
    );
endinterface

// File: rtl/imm_extend_pipe_skid_buffer.sv
// Registered valid/ready stage with one skid entry; owns all handshake state.
module skid_buffer #(
    parameter int unsigned DATA_W = 34
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;
    logic              accept_c;
    logic              xfer_c;

    // Next-state: refill main from skid first, otherwise place the accepted item.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        accept_c     = in_valid_i && in_ready_q;
        xfer_c       = main_valid_q && out_ready_i;
        if (skid_valid_q) begin
            if (xfer_c) begin
                main_data_d  = skid_data_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            if (!main_valid_q || xfer_c) begin
                main_data_d  = in_data_i;
                main_valid_d = 1'b1;
            end else begin
                skid_data_d  = in_data_i;
                skid_valid_d = 1'b1;
            end
        end else if (xfer_c) begin
            main_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers; in_ready is held low throughout reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: combinational extension feeding a skid-buffered output register.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_extend_pipe_if.slave  bus
);

    localparam int unsigned DATA_W = OUT_W + 2;

    // Branch mode needs at least the sign bit plus two shift positions of headroom.
    generate
        if (!(OUT_W > IN_W + 1) || (OUT_W > EXT_MAX_W)) begin : g_bad_width
            $error("imm_extend_pipe: OUT_W must exceed IN_W+1 and not exceed EXT_MAX_W");
        end
    endgenerate

    logic [OUT_W-1:0]  ext_c;
    logic [DATA_W-1:0] out_data_c;

    // Extension of the currently presented immediate; captured only on accept.
    assign ext_c = OUT_W'(ext_imm(EXT_MAX_W'(bus.imm_in), imm_mode_e'(bus.mode), IN_W, OUT_W));

    skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   ({bus.mode, ext_c}),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (out_data_c)
    );

    assign bus.out_mode = out_data_c[DATA_W-1 -: 2];
    assign bus.imm_out  = out_data_c[OUT_W-1:0];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: a 16->32 instance and a 12->32 instance.
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) if16 ();
    imm_extend_pipe_if #(.IN_W(12), .OUT_W(32)) if12 ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    imm_extend_pipe #(.IN_W(12), .OUT_W(32)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(if12.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [33:0] q16[$];
    logic [33:0] q12[$];
    int          xfers16;
    int          xfers12;
    bit          hold16;
    bit          hold12;
    logic [33:0] held16;
    logic [33:0] held12;

    // Monitor for the 16-bit instance: ordering/value scoreboard plus hold-while-stalled check.
    always @(negedge clk) begin
        logic [33:0] exp_v;
        if (hold16 && if16.out_valid) begin
            checks++;
            if ({if16.out_mode, if16.imm_out} !== held16) begin
                errors++;
                $display("FAIL hold16: got %h required %h", {if16.out_mode, if16.imm_out}, held16);
            end
        end
        hold16 = rst_n && if16.out_valid && !if16.out_ready;
        held16 = {if16.out_mode, if16.imm_out};
        if (rst_n && if16.out_valid && if16.out_ready) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL out16_unexpected: got %h required none", {if16.out_mode, if16.imm_out});
            end else begin
                exp_v = q16.pop_front();
                if ({if16.out_mode, if16.imm_out} !== exp_v) begin
                    errors++;
                    $display("FAIL out16: got %h required %h", {if16.out_mode, if16.imm_out}, exp_v);
                end
            end
            xfers16++;
        end
    end

    // Monitor for the 12-bit instance.
    always @(negedge clk) begin
        logic [33:0] exp_v;
        if (hold12 && if12.out_valid) begin
            checks++;
            if ({if12.out_mode, if12.imm_out} !== held12) begin
                errors++;
                $display("FAIL hold12: got %h required %h", {if12.out_mode, if12.imm_out}, held12);
            end
        end
        hold12 = rst_n && if12.out_valid && !if12.out_ready;
        held12 = {if12.out_mode, if12.imm_out};
        if (rst_n && if12.out_valid && if12.out_ready) begin
            checks++;
            if (q12.size() == 0) begin
                errors++;
                $display("FAIL out12_unexpected: got %h required none", {if12.out_mode, if12.imm_out});
            end else begin
                exp_v = q12.pop_front();
                if ({if12.out_mode, if12.imm_out} !== exp_v) begin
                    errors++;
                    $display("FAIL out12: got %h required %h", {if12.out_mode, if12.imm_out}, exp_v);
                end
            end
            xfers12++;
        end
    end

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Present one item on the 16-bit instance and wait (bounded) until it is accepted.
    task automatic send16(input logic [15:0] imm, input logic [1:0] m, input logic [31:0] exp_v,
                          input bit want_ready);
        int n;
        if16.in_valid = 1'b1;
        if16.imm_in   = imm;
        if16.mode     = m;
        if (want_ready) check("in_ready16", 34'(if16.in_ready), 34'(1));
        n = 0;
        while (if16.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send16_timeout: got in_ready=%b required 1", if16.in_ready);
        end else begin
            q16.push_back({m, exp_v});
            @(posedge clk); #1;
        end
        if16.in_valid = 1'b0;
    endtask

    task automatic send12(input logic [11:0] imm, input logic [1:0] m, input logic [31:0] exp_v);
        int n;
        if12.in_valid = 1'b1;
        if12.imm_in   = imm;
        if12.mode     = m;
        n = 0;
        while (if12.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send12_timeout: got in_ready=%b required 1", if12.in_ready);
        end else begin
            q12.push_back({m, exp_v});
            @(posedge clk); #1;
            check("lat12_valid", 34'(if12.out_valid), 34'(1));
        end
        if12.in_valid = 1'b0;
    endtask

    // Let the 16-bit instance empty with out_ready high; bounded.
    task automatic drain16();
        int n;
        if16.out_ready = 1'b1;
        n = 0;
        while (if16.out_valid === 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain16_valid", 34'(if16.out_valid), 34'(0));
        check("drain16_queue", 34'(q16.size()), 34'(0));
    endtask

    logic [15:0] s_imm [8];
    logic [1:0]  s_mode[8];
    logic [31:0] s_exp [8];

    initial begin
        int x0;
        checks = 0; errors = 0; xfers16 = 0; xfers12 = 0;
        hold16 = 0; hold12 = 0; held16 = '0; held12 = '0;
        rst_n = 1'b0;
        if16.in_valid = 0; if16.imm_in = '0; if16.mode = '0; if16.out_ready = 1'b1;
        if12.in_valid = 0; if12.imm_in = '0; if12.mode = '0; if12.out_ready = 1'b1;

        s_imm[0] = 16'h0001; s_mode[0] = MODE_SIGN;   s_exp[0] = 32'h00000001;
        s_imm[1] = 16'h8001; s_mode[1] = MODE_ZERO;   s_exp[1] = 32'h00008001;
        s_imm[2] = 16'hBEEF; s_mode[2] = MODE_UPPER;  s_exp[2] = 32'hBEEF0000;
        s_imm[3] = 16'h0010; s_mode[3] = MODE_BRANCH; s_exp[3] = 32'h00000040;
        s_imm[4] = 16'h8000; s_mode[4] = MODE_SIGN;   s_exp[4] = 32'hFFFF8000;
        s_imm[5] = 16'h7FFF; s_mode[5] = MODE_ZERO;   s_exp[5] = 32'h00007FFF;
        s_imm[6] = 16'h0001; s_mode[6] = MODE_UPPER;  s_exp[6] = 32'h00010000;
        s_imm[7] = 16'h8000; s_mode[7] = MODE_BRANCH; s_exp[7] = 32'hFFFE0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 34'(if16.out_valid), 34'(0));
        check("rst_imm_out",   34'(if16.imm_out),   34'(0));
        check("rst_out_mode",  34'(if16.out_mode),  34'(0));
        check("rst_in_ready",  34'(if16.in_ready),  34'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 34'(if16.in_ready), 34'(1));

        // Mode coverage, one-cycle latency
        send16(16'h003C, MODE_SIGN,   32'h0000003C, 1); check("lat_valid", 34'(if16.out_valid), 34'(1));
        send16(16'hFFC3, MODE_SIGN,   32'hFFFFFFC3, 1); check("lat_valid", 34'(if16.out_valid), 34'(1));
        send16(16'h0000, MODE_SIGN,   32'h00000000, 1); check("lat_valid", 34'(if16.out_valid), 34'(1));
        send16(16'hFFC3, MODE_ZERO,   32'h0000FFC3, 1); check("lat_valid", 34'(if16.out_valid), 34'(1));
        send16(16'h1234, MODE_UPPER,  32'h12340000, 1); check("lat_valid", 34'(if16.out_valid), 34'(1));
        send16(16'hFFFF, MODE_BRANCH, 32'hFFFFFFFC, 1); check("lat_valid", 34'(if16.out_valid), 34'(1));
        send16(16'h7FFF, MODE_BRANCH, 32'h0001FFFC, 1); check("lat_valid", 34'(if16.out_valid), 34'(1));
        drain16();

        // Back-to-back streaming at full rate
        x0 = xfers16;
        for (int i = 0; i < 8; i++) begin
            send16(s_imm[i], s_mode[i], s_exp[i], 1);
            check("stream_valid", 34'(if16.out_valid), 34'(1));
        end
        @(posedge clk); #1;
        check("stream_count", 34'(xfers16 - x0), 34'(8));
        drain16();

        // Backpressure fills main then skid
        if16.out_ready = 1'b0;
        send16(16'h0001, MODE_SIGN, 32'h00000001, 1);
        send16(16'h0002, MODE_SIGN, 32'h00000002, 1);
        check("bp_in_ready", 34'(if16.in_ready), 34'(0));
        check("bp_imm_out",  34'(if16.imm_out),  34'(32'h00000001));

        // Stalled inputs must not be captured
        if16.in_valid = 1'b1; if16.imm_in = 16'hDEAD; if16.mode = MODE_UPPER;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if16.imm_in = 16'hDEAD ^ 16'(i + 1); if16.mode = 2'(i);
            check("stall_in_ready", 34'(if16.in_ready), 34'(0));
            check("stall_imm_out",  34'(if16.imm_out),  34'(32'h00000001));
        end
        if16.in_valid = 1'b0;

        // Release backpressure: A then B, then room again
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_second", 34'(if16.imm_out), 34'(32'h00000002));
        @(posedge clk); #1;
        check("bp_ready_back", 34'(if16.in_ready), 34'(1));
        check("bp_empty", 34'(if16.out_valid), 34'(0));
        check("bp_queue", 34'(q16.size()), 34'(0));

        // Reset with main and skid both occupied
        if16.out_ready = 1'b0;
        send16(16'h0055, MODE_ZERO, 32'h00000055, 1);
        send16(16'h00AA, MODE_ZERO, 32'h000000AA, 1);
        check("full_in_ready", 34'(if16.in_ready), 34'(0));
        rst_n = 1'b0;
        q16.delete();
        @(posedge clk); #1;
        check("mid_rst_valid",    34'(if16.out_valid), 34'(0));
        check("mid_rst_imm",      34'(if16.imm_out),   34'(0));
        check("mid_rst_in_ready", 34'(if16.in_ready),  34'(0));
        rst_n = 1'b1;
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 34'(if16.in_ready),  34'(1));
        check("post_rst_valid",    34'(if16.out_valid), 34'(0));
        send16(16'h8000, MODE_SIGN, 32'hFFFF8000, 1);
        check("post_rst_imm", 34'(if16.imm_out), 34'(32'hFFFF8000));
        drain16();

        // Narrow-input instance
        send12(12'h800, MODE_SIGN,   32'hFFFFF800);
        send12(12'hABC, MODE_UPPER,  32'hABC00000);
        send12(12'hFFF, MODE_BRANCH, 32'hFFFFFFFC);
        send12(12'h800, MODE_ZERO,   32'h00000800);
        repeat (3) @(posedge clk);
        #1;
        check("n12_count", 34'(xfers12), 34'(4));
        check("n12_queue", 34'(q12.size()), 34'(0));
        check("n12_empty", 34'(if12.out_valid), 34'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
